// File: rtl/accum_frame_if.sv
// Beat-input and frame-result handshake bundle for accum_frame.
interface accum_frame_if #(
    parameter int NB_DATA = 3,
    parameter int NB_ACC  = 2 * NB_DATA
);
    logic               i_valid;
    logic               o_ready;
    logic [NB_DATA-1:0] i_data1;
    logic [NB_DATA-1:0] i_data2;
    logic [1:0]         i_sel;
    logic               o_valid;
    logic               i_ready;
    logic [NB_ACC-1:0]  o_data;
    logic               o_overflow;

    modport slave (
        input  i_valid, i_data1, i_data2, i_sel, i_ready,
        output o_ready, o_valid, o_data, o_overflow
    );

    modport master (
        output i_valid, i_data1, i_data2, i_sel, i_ready,
        input  o_ready, o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/accum_frame.sv
// Framed, handshaked operand accumulator with sticky overflow.
// Define ACCUM_FRAME_SATURATE_EN to clamp at full scale instead of wrapping.
//
//  state  | meaning
//  IDLE   | waiting for i_start with non-zero i_len
//  ACC    | accepting beats (o_ready=1) until len beats counted
//  DONE   | frame sum presented (o_valid=1) until consumer takes it
module accum_frame #(
    parameter int NB_DATA = 3,
    parameter int NB_ACC  = 2 * NB_DATA,
    parameter int NB_CNT  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic [NB_CNT-1:0] i_len,
    output logic              o_busy,
    accum_frame_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [NB_ACC-1:0]   acc_q, acc_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic [NB_CNT-1:0]   len_q, len_d;
    logic                ovf_q, ovf_d;

    logic                start_ok;
    logic                beat;
    logic                last_beat;
    logic                handoff;
    logic [NB_DATA:0]    operand;
    logic [NB_ACC:0]     sum;

    assign start_ok  = (state_q == S_IDLE) && i_start && (i_len != '0);
    assign beat      = (state_q == S_ACC) && bus.i_valid;
    assign last_beat = beat && (cnt_q == (len_q - NB_CNT'(1)));
    assign handoff   = (state_q == S_DONE) && bus.i_ready;

    always_comb begin
        operand = '0;
        case (bus.i_sel)
            2'b00:   operand = {1'b0, bus.i_data2};
            2'b01:   operand = {1'b0, bus.i_data1} + {1'b0, bus.i_data2};
            2'b10:   operand = {1'b0, bus.i_data1};
            default: operand = '0;
        endcase
    end

    // Extra top bit of sum is the carry out of the NB_ACC-bit add.
    assign sum = {1'b0, acc_q} + {{(NB_ACC - NB_DATA){1'b0}}, operand};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_ok)  state_d = S_ACC;
                S_ACC:   if (last_beat) state_d = S_DONE;
                S_DONE:  if (handoff)   state_d = S_IDLE;
                default:                state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
            len_d = '0;
            ovf_d = 1'b0;
        end else if (start_ok) begin
            acc_d = '0;
            cnt_d = '0;
            len_d = i_len;
            ovf_d = 1'b0;
        end else if (beat) begin
            cnt_d = cnt_q + NB_CNT'(1);
            ovf_d = ovf_q | sum[NB_ACC];
`ifdef ACCUM_FRAME_SATURATE_EN
            // Once clamped, any further non-zero operand carries again, so it stays at full scale.
            acc_d = sum[NB_ACC] ? '1 : sum[NB_ACC-1:0];
`else
            acc_d = sum[NB_ACC-1:0];
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        bus.o_ready    = (state_q == S_ACC);
        bus.o_valid    = (state_q == S_DONE);
        bus.o_data     = acc_q;
        bus.o_overflow = ovf_q;
        o_busy         = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_accum_frame.sv
// Scoreboard bench for accum_frame: directed scenarios plus randomized frames.
module tb_accum_frame;
    localparam int NB_DATA = 3;
    localparam int NB_ACC  = 6;
    localparam int NB_CNT  = 4;
    localparam int FULL    = (1 << NB_ACC) - 1;
`ifdef ACCUM_FRAME_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic              i_clear;
    logic              i_start;
    logic [NB_CNT-1:0] i_len;
    logic              o_busy;

    accum_frame_if #(.NB_DATA(NB_DATA), .NB_ACC(NB_ACC)) ifc ();

    accum_frame #(.NB_DATA(NB_DATA), .NB_ACC(NB_ACC), .NB_CNT(NB_CNT)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_start (i_start),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .bus     (ifc.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [NB_ACC:0] exp_q[$];

    int beat_sel[16];
    int beat_d1[16];
    int beat_d2[16];
    int beat_gap[16];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: true integer frame total, then reduce to the accumulator width.
    function automatic logic [NB_ACC:0] model(input int total);
        logic [NB_ACC:0] r;
        if (total > FULL) begin
            r[NB_ACC] = 1'b1;
            r[NB_ACC-1:0] = SAT ? NB_ACC'(FULL) : NB_ACC'(total % (FULL + 1));
        end else begin
            r = {1'b0, NB_ACC'(total)};
        end
        return r;
    endfunction

    function automatic int operand_of(input int sel, input int d1, input int d2);
        case (sel)
            0:       return d2;
            1:       return d1 + d2;
            2:       return d1;
            default: return 0;
        endcase
    endfunction

    always @(negedge i_clk) begin : monitor
        logic [NB_ACC:0] e;
        if (i_rst_n && !i_clear && ifc.o_valid && ifc.i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("frame_data", ifc.o_data, e[NB_ACC-1:0]);
                check("frame_ovf", ifc.o_overflow, e[NB_ACC]);
            end
        end
    end

    task automatic start_frame(input int len);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_len   = NB_CNT'(len);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_len   = NB_CNT'($urandom);
    endtask

    task automatic send_beat(input int i);
        bit ok;
        repeat (beat_gap[i]) begin
            ifc.i_valid = 1'b0;
            @(posedge i_clk); #1;
        end
        ifc.i_valid = 1'b1;
        ifc.i_sel   = 2'(beat_sel[i]);
        ifc.i_data1 = NB_DATA'(beat_d1[i]);
        ifc.i_data2 = NB_DATA'(beat_d2[i]);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (ifc.o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
        @(posedge i_clk); #1;
        ifc.i_valid = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit push);
        int total;
        total = 0;
        start_frame(len);
        for (int i = 0; i < len; i++) begin
            total += operand_of(beat_sel[i], beat_d1[i], beat_d2[i]);
            if (i == len - 1 && push) exp_q.push_back(model(total));
            send_beat(i);
        end
        @(negedge i_clk);
        check("result_latency", ifc.o_valid, 1);
        check("ready_drop", ifc.o_ready, 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic fill_uniform(input int len, input int sel, input int d1, input int d2);
        for (int i = 0; i < 16; i++) begin
            beat_sel[i] = sel;
            beat_d1[i]  = d1;
            beat_d2[i]  = d2;
            beat_gap[i] = 0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        i_rst_n     = 1'b0;
        i_clear     = 1'b0;
        i_start     = 1'b0;
        i_len       = '0;
        ifc.i_valid = 1'b0;
        ifc.i_data1 = '0;
        ifc.i_data2 = '0;
        ifc.i_sel   = '0;
        ifc.i_ready = 1'b0;

        @(negedge i_clk);
        check("rst_valid", ifc.o_valid, 0);
        check("rst_ready", ifc.o_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", ifc.o_data, 0);
        check("rst_ovf", ifc.o_overflow, 0);
        i_rst_n = 1'b1;

        // basic frame
        ifc.i_ready = 1'b1;
        fill_uniform(4, 1, 7, 7);
        run_frame(4, 1'b1);
        wait_idle();

        // overflow frame
        fill_uniform(5, 1, 7, 7);
        run_frame(5, 1'b1);
        wait_idle();

        // gaps and select mix
        fill_uniform(3, 0, 0, 0);
        beat_sel[0] = 0; beat_d1[0] = 6; beat_d2[0] = 5; beat_gap[0] = 0;
        beat_sel[1] = 2; beat_d1[1] = 3; beat_d2[1] = 7; beat_gap[1] = 2;
        beat_sel[2] = 3; beat_d1[2] = 7; beat_d2[2] = 7; beat_gap[2] = 0;
        run_frame(3, 1'b1);
        wait_idle();

        // backpressure with ignored start in DONE
        ifc.i_ready = 1'b0;
        fill_uniform(4, 2, 5, 1);
        run_frame(4, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                @(posedge i_clk); #1;
                i_start = 1'b1;
                i_len   = NB_CNT'(3);
                @(posedge i_clk); #1;
                i_start = 1'b0;
            end
            @(negedge i_clk);
            check("bp_valid", ifc.o_valid, 1);
            check("bp_data", ifc.o_data, 20);
            check("bp_ready", ifc.o_ready, 0);
            check("bp_busy", o_busy, 1);
        end
        @(posedge i_clk); #1;
        ifc.i_ready = 1'b1;
        wait_idle();
        check("bp_valid_after", ifc.o_valid, 0);
        check("bp_data_retained", ifc.o_data, 20);

        // synchronous clear mid-frame, with a beat offered in the same cycle
        fill_uniform(5, 1, 7, 7);
        start_frame(5);
        send_beat(0);
        send_beat(1);
        ifc.i_valid = 1'b1;
        i_clear     = 1'b1;
        @(posedge i_clk); #1;
        i_clear     = 1'b0;
        ifc.i_valid = 1'b0;
        @(negedge i_clk);
        check("clr_busy", o_busy, 0);
        check("clr_ready", ifc.o_ready, 0);
        check("clr_valid", ifc.o_valid, 0);
        check("clr_data", ifc.o_data, 0);
        check("clr_ovf", ifc.o_overflow, 0);

        // asynchronous reset mid-frame
        start_frame(4);
        send_beat(0);
        send_beat(1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_ready", ifc.o_ready, 0);
        check("arst_data", ifc.o_data, 0);
        check("arst_ovf", ifc.o_overflow, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        fill_uniform(1, 0, 1, 4);
        run_frame(1, 1'b1);
        wait_idle();

        // zero length start
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_len   = '0;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("zlen_busy", o_busy, 0);
            check("zlen_valid", ifc.o_valid, 0);
        end

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 15);
            for (int i = 0; i < 16; i++) begin
                beat_sel[i] = $urandom_range(0, 3);
                beat_d1[i]  = $urandom_range(0, 7);
                beat_d2[i]  = $urandom_range(0, 7);
                beat_gap[i] = $urandom_range(0, 2);
            end
            ifc.i_ready = 1'($urandom_range(0, 1));
            run_frame(len, 1'b1);
            if (!ifc.i_ready) begin
                repeat ($urandom_range(1, 4)) @(posedge i_clk);
                #1;
                ifc.i_ready = 1'b1;
            end
            wait_idle();
        end

        repeat (5) @(negedge i_clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
